// File: rtl/remote_load_resp_pkg.sv
// Shared types for the remote load response path.
//
// bsg_manycore_load_info_s describes how a returned load word must be
// post-processed and where it is written back. load_resp_s bundles one
// network response (destination register, load info, raw word) so the
// response buffer stores it as a single payload.
package remote_load_resp_pkg;

    localparam int data_width_gp     = 32;
    localparam int reg_addr_width_gp = 5;

    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    typedef struct packed {
        logic [reg_addr_width_gp-1:0] reg_id;
        bsg_manycore_load_info_s      info;
        logic [data_width_gp-1:0]     data;
    } load_resp_s;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO used to buffer returned load responses.
//
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset (control only)
//   ready_o          space available; does not depend on yumi_i
//   data_i, v_i      enqueue payload and request (only taken when ready_o)
//   v_o, data_o      head entry valid and payload, registered
//   yumi_i           consume the head entry (only meaningful when v_o)
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    assign enq     = v_i & ~full;
    assign deq     = yumi_i & ~empty;
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem[rd_ptr];

    // Storage carries no reset; empty/full decide what is visible.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            // Occupancy only changes when exactly one side moves.
            if (enq && !deq) begin
                empty <= 1'b0;
                full  <= (~wr_ptr == rd_ptr);
            end else if (deq && !enq) begin
                full  <= 1'b0;
                empty <= (~rd_ptr == wr_ptr);
            end
        end
    end

endmodule

// File: rtl/remote_load_resp.sv
// Return path for remote loads and icache fetches.
//
// Buffers network responses, extends byte/half loads for the integer RF,
// routes each response to the integer RF, FP RF or icache fill port, and
// counts outstanding remote requests so the core can stall on credits.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   returned_v_i/data_i/reg_id_i/info_i, returned_yumi_o
//                                  network response in, consumed flag out
//   remote_req_send_i, store_ack_i request issued / store-amo credit back
//   out_credits_o, credits_full_o  outstanding count and full flag
//   int_wb_*                       integer RF write (extended data)
//   float_wb_*                     FP RF write (raw data)
//   ifill_*                        icache fill (raw data)
module remote_load_resp
    import remote_load_resp_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int max_out_credits_p = 32,
    parameter int reg_addr_width_p  = 5,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        returned_v_i,
    input  logic [data_width_p-1:0]     returned_data_i,
    input  logic [reg_addr_width_p-1:0] returned_reg_id_i,
    input  bsg_manycore_load_info_s     returned_info_i,
    output logic                        returned_yumi_o,

    input  logic                        remote_req_send_i,
    input  logic                        store_ack_i,
    output logic [credit_width_lp-1:0]  out_credits_o,
    output logic                        credits_full_o,

    output logic                        int_wb_v_o,
    output logic [reg_addr_width_p-1:0] int_wb_id_o,
    output logic [data_width_p-1:0]     int_wb_data_o,
    input  logic                        int_wb_yumi_i,

    output logic                        float_wb_v_o,
    output logic [reg_addr_width_p-1:0] float_wb_id_o,
    output logic [data_width_p-1:0]     float_wb_data_o,
    input  logic                        float_wb_yumi_i,

    output logic                        ifill_v_o,
    output logic [data_width_p-1:0]     ifill_data_o,
    input  logic                        ifill_yumi_i
);

    localparam logic [credit_width_lp-1:0]        max_credits_lp =
        credit_width_lp'(max_out_credits_p);
    localparam logic signed [credit_width_lp+1:0] max_credits_s_lp =
        (credit_width_lp + 2)'(max_out_credits_p);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic is_unsigned);
        return {{24{b[7] & ~is_unsigned}}, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic is_unsigned);
        return {{16{h[15] & ~is_unsigned}}, h};
    endfunction

    // Clamp the next credit count into [0, max]; out-of-range values are
    // protocol errors caught by the assertions below.
    function automatic logic [credit_width_lp-1:0] saturate_credits(
        input logic signed [credit_width_lp+1:0] s
    );
        if (s[credit_width_lp+1]) begin
            return '0;
        end
        if (s > max_credits_s_lp) begin
            return max_credits_lp;
        end
        return s[credit_width_lp-1:0];
    endfunction

    load_resp_s enq_resp;
    load_resp_s head;
    logic       fifo_ready;
    logic       head_v;
    logic       head_yumi;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;

    // Ingress: accept whenever the buffer has room; the response is only
    // visible at the head from the next cycle on.
    assign enq_resp = '{reg_id: returned_reg_id_i, info: returned_info_i, data: returned_data_i};
    assign returned_yumi_o = returned_v_i & fifo_ready & ~reset_i;

    bsg_two_fifo #(
        .width_p($bits(load_resp_s))
    ) resp_buffer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (fifo_ready),
        .data_i  (enq_resp),
        .v_i     (returned_yumi_o),
        .v_o     (head_v),
        .data_o  (head),
        .yumi_i  (head_yumi)
    );

    // Routing: icache fetch wins over float_wb; everything else is integer.
    always_comb begin
        ifill_v_o    = 1'b0;
        float_wb_v_o = 1'b0;
        int_wb_v_o   = 1'b0;
        if (head_v) begin
            if (head.info.icache_fetch) begin
                ifill_v_o = 1'b1;
            end else if (head.info.float_wb) begin
                float_wb_v_o = 1'b1;
            end else begin
                int_wb_v_o = 1'b1;
            end
        end
    end

    // Yumi on a port that is not selected has no effect.
    assign head_yumi = (ifill_v_o & ifill_yumi_i)
                     | (float_wb_v_o & float_wb_yumi_i)
                     | (int_wb_v_o & int_wb_yumi_i);

    // Byte/half extraction for the integer path; part_sel[0] is unused for halves.
    always_comb begin
        byte_sel      = head.data[{head.info.part_sel, 3'b000} +: 8];
        half_sel      = head.data[{head.info.part_sel[1], 4'b0000} +: 16];
        int_wb_data_o = head.data;
        if (head.info.is_byte_op) begin
            int_wb_data_o = extend_byte(byte_sel, head.info.is_unsigned_op);
        end else if (head.info.is_hex_op) begin
            int_wb_data_o = extend_half(half_sel, head.info.is_unsigned_op);
        end
    end

    assign int_wb_id_o     = head.reg_id;
    assign float_wb_id_o   = head.reg_id;
    assign float_wb_data_o = head.data;
    assign ifill_data_o    = head.data;

    // Credit counter: +1 per request sent, -1 per returned response and per
    // store ack (both in one cycle count -2).
    logic [credit_width_lp-1:0]        credits;
    logic [1:0]                        dec;
    logic signed [credit_width_lp+1:0] credit_sum;

    assign dec = {1'b0, returned_yumi_o} + {1'b0, store_ack_i};
    assign credit_sum = $signed({2'b00, credits})
                      + $signed({{(credit_width_lp + 1){1'b0}}, remote_req_send_i})
                      - $signed({{credit_width_lp{1'b0}}, dec});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits <= '0;
        end else begin
            credits <= saturate_credits(credit_sum);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(credit_sum > max_credits_s_lp))
                else $error("remote_load_resp: credit increment while full");
            assert (!credit_sum[credit_width_lp+1])
                else $error("remote_load_resp: credit decrement below zero");
        end
    end

    assign out_credits_o  = credits;
    assign credits_full_o = (credits == max_credits_lp);

endmodule

// File: tb/tb_remote_load_resp.sv
module tb_remote_load_resp;
    import remote_load_resp_pkg::*;

    localparam int MAXC = 4;
    localparam int CW   = $clog2(MAXC + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    returned_v;
    logic [31:0]             returned_data;
    logic [4:0]              returned_reg_id;
    bsg_manycore_load_info_s returned_info;
    logic                    returned_yumi;
    logic                    remote_req_send;
    logic                    store_ack;
    logic [CW-1:0]           out_credits;
    logic                    credits_full;
    logic                    int_wb_v;
    logic [4:0]              int_wb_id;
    logic [31:0]             int_wb_data;
    logic                    int_wb_yumi;
    logic                    float_wb_v;
    logic [4:0]              float_wb_id;
    logic [31:0]             float_wb_data;
    logic                    float_wb_yumi;
    logic                    ifill_v;
    logic [31:0]             ifill_data;
    logic                    ifill_yumi;

    remote_load_resp #(
        .data_width_p(32), .max_out_credits_p(MAXC), .reg_addr_width_p(5)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .returned_v_i(returned_v), .returned_data_i(returned_data),
        .returned_reg_id_i(returned_reg_id), .returned_info_i(returned_info),
        .returned_yumi_o(returned_yumi),
        .remote_req_send_i(remote_req_send), .store_ack_i(store_ack),
        .out_credits_o(out_credits), .credits_full_o(credits_full),
        .int_wb_v_o(int_wb_v), .int_wb_id_o(int_wb_id), .int_wb_data_o(int_wb_data),
        .int_wb_yumi_i(int_wb_yumi),
        .float_wb_v_o(float_wb_v), .float_wb_id_o(float_wb_id), .float_wb_data_o(float_wb_data),
        .float_wb_yumi_i(float_wb_yumi),
        .ifill_v_o(ifill_v), .ifill_data_o(ifill_data), .ifill_yumi_i(ifill_yumi)
    );

    always #5 clk = ~clk;

    // Reference model: queue of buffered responses plus an integer credit count.
    typedef struct {
        logic [31:0]             word;
        logic [4:0]              id;
        bsg_manycore_load_info_s info;
    } resp_t;

    resp_t q[$];
    int    credits_m = 0;
    int    checks = 0;
    int    errors = 0;

    // 0 = integer RF, 1 = FP RF, 2 = icache fill
    function automatic int port_of(input bsg_manycore_load_info_s inf);
        if (inf.icache_fetch) return 2;
        if (inf.float_wb) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] expect_int(input logic [31:0] w, input bsg_manycore_load_info_s inf);
        int unsigned v;
        longint      s;
        if (inf.is_byte_op) begin
            v = (w >> (8 * inf.part_sel)) & 32'hFF;
            s = v;
            if (!inf.is_unsigned_op && v >= 128) s = s - 256;
            return s[31:0];
        end
        if (inf.is_hex_op) begin
            v = (w >> (16 * (inf.part_sel / 2))) & 32'hFFFF;
            s = v;
            if (!inf.is_unsigned_op && v >= 32768) s = s - 65536;
            return s[31:0];
        end
        return w;
    endfunction

    function automatic logic exp_ryumi();
        return returned_v && !reset && q.size() < 2;
    endfunction

    task automatic apply(input logic v, input logic [31:0] w, input logic [4:0] id,
                         input bsg_manycore_load_info_s inf, input logic send,
                         input logic ack, input logic [2:0] yumis);
        returned_v      = v;
        returned_data   = w;
        returned_reg_id = id;
        returned_info   = inf;
        remote_req_send = send;
        store_ack       = ack;
        {ifill_yumi, float_wb_yumi, int_wb_yumi} = yumis;
        #1;
    endtask

    // Advance the model by the inputs currently applied, then clock the DUT.
    task automatic commit();
        logic acc;
        logic pop;
        acc = exp_ryumi();
        pop = 1'b0;
        if (q.size() > 0) begin
            case (port_of(q[0].info))
                0:       pop = int_wb_yumi;
                1:       pop = float_wb_yumi;
                default: pop = ifill_yumi;
            endcase
        end
        if (reset) begin
            q.delete();
            credits_m = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{returned_data, returned_reg_id, returned_info});
            credits_m = credits_m + int'(remote_req_send) - int'(acc) - int'(store_ack);
            if (credits_m < 0) credits_m = 0;
            if (credits_m > MAXC) credits_m = MAXC;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [2:0] yumis);
        apply(1'b0, 32'h0, 5'd0, '0, 1'b0, 1'b0, yumis);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b1, 32'hDEAD_BEEF, 5'd1, '0, 1'b0, 1'b0, 3'b000);
        commit();
        checks++;
        if (returned_yumi !== 1'b0) begin
            errors++;
            $display("FAIL reset_yumi: got %b want 0", returned_yumi);
        end
        commit();
        reset = 1'b0;
        idle(3'b000);
        checks++;
        if (out_credits !== '0 || credits_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_credits: got %0d/%b want 0/0", out_credits, credits_full);
        end
        checks++;
        if ({ifill_v, float_wb_v, int_wb_v} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valids: got %b want 000", {ifill_v, float_wb_v, int_wb_v});
        end
    endtask

    task automatic test_routing();
        logic [31:0] tbl_word [6] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01,
                                      32'h80FF_7F01, 32'h3F80_0000, 32'h0050_0093};
        logic [6:0]  tbl_info [6] = '{7'b0001011, 7'b0011011, 7'b0000110,
                                      7'b0010100, 7'b1000000, 7'b1100000};
        logic [4:0]  tbl_id   [6] = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd2, 5'd0};
        logic [31:0] tbl_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                      32'h0000_7F01, 32'h3F80_0000, 32'h0050_0093};
        int          tbl_port [6] = '{0, 0, 0, 0, 1, 2};
        for (int i = 0; i < 30; i++) begin
            logic [31:0] w;
            logic [31:0] r;
            logic [4:0]  id;
            bsg_manycore_load_info_s inf;
            logic [31:0] exp_d;
            logic [31:0] got_d;
            logic [4:0]  got_id;
            int          p;
            if (i < 6) begin
                w = tbl_word[i]; inf = bsg_manycore_load_info_s'(tbl_info[i]); id = tbl_id[i];
                exp_d = tbl_exp[i]; p = tbl_port[i];
            end else begin
                w = $urandom(); r = $urandom(); id = r[4:0];
                inf = bsg_manycore_load_info_s'(r[14:8]);
                p = port_of(inf);
                exp_d = (p == 0) ? expect_int(w, inf) : w;
            end
            apply(1'b0, 32'h0, 5'd0, '0, 1'b1, 1'b0, 3'b000);
            commit();
            apply(1'b1, w, id, inf, 1'b0, 1'b0, 3'b000);
            checks++;
            if (returned_yumi !== 1'b1) begin
                errors++;
                $display("FAIL route_accept %0d: got %b want 1", i, returned_yumi);
            end
            checks++;
            if ({ifill_v, float_wb_v, int_wb_v} !== 3'b000) begin
                errors++;
                $display("FAIL route_latency %0d: got %b want 000", i, {ifill_v, float_wb_v, int_wb_v});
            end
            commit();
            idle(3'b111);
            checks++;
            if ({ifill_v, float_wb_v, int_wb_v} !== (3'b001 << p)) begin
                errors++;
                $display("FAIL route_valid %0d: got %b want %b", i, {ifill_v, float_wb_v, int_wb_v}, 3'b001 << p);
            end
            got_d  = (p == 0) ? int_wb_data : (p == 1) ? float_wb_data : ifill_data;
            got_id = (p == 0) ? int_wb_id : float_wb_id;
            checks++;
            if (got_d !== exp_d) begin
                errors++;
                $display("FAIL route_data %0d: got %h want %h", i, got_d, exp_d);
            end
            if (p < 2) begin
                checks++;
                if (got_id !== id) begin
                    errors++;
                    $display("FAIL route_id %0d: got %0d want %0d", i, got_id, id);
                end
            end
            commit();
        end
        idle(3'b000);
        checks++;
        if (out_credits !== '0) begin
            errors++;
            $display("FAIL route_credits: got %0d want 0", out_credits);
        end
    endtask

    task automatic test_hold();
        bsg_manycore_load_info_s inf;
        inf = bsg_manycore_load_info_s'(7'b0001001);
        apply(1'b0, 32'h0, 5'd0, '0, 1'b1, 1'b0, 3'b000);
        commit();
        apply(1'b1, 32'h1234_A5C3, 5'd9, inf, 1'b0, 1'b0, 3'b000);
        commit();
        for (int k = 0; k < 3; k++) begin
            idle(3'b110);
            checks++;
            if (int_wb_v !== 1'b1 || int_wb_data !== 32'hFFFF_FFA5 || int_wb_id !== 5'd9) begin
                errors++;
                $display("FAIL hold_stable %0d: got v=%b d=%h id=%0d want v=1 d=ffffffa5 id=9",
                         k, int_wb_v, int_wb_data, int_wb_id);
            end
            commit();
        end
        idle(3'b001);
        commit();
        idle(3'b000);
        checks++;
        if (int_wb_v !== 1'b0) begin
            errors++;
            $display("FAIL hold_dequeue: got %b want 0", int_wb_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
        logic        exp_acc [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] seen [$];
        logic        pending;
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 32'h0, 5'd0, '0, 1'b1, 1'b0, 3'b000);
            commit();
        end
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, words[k], 5'(k), '0, 1'b0, 1'b0, 3'b000);
            checks++;
            if (returned_yumi !== exp_acc[k]) begin
                errors++;
                $display("FAIL b2b_accept %0d: got %b want %b", k, returned_yumi, exp_acc[k]);
            end
            commit();
        end
        pending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            apply(pending, words[2], 5'd2, '0, 1'b0, 1'b0, 3'b111);
            checks++;
            if (returned_yumi !== exp_ryumi()) begin
                errors++;
                $display("FAIL b2b_refill %0d: got %b want %b", k, returned_yumi, exp_ryumi());
            end
            if (int_wb_v === 1'b1) seen.push_back(int_wb_data);
            if (returned_yumi === 1'b1) pending = 1'b0;
            commit();
        end
        checks++;
        if (seen.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (seen[k] !== words[k]) begin
                    errors++;
                    $display("FAIL b2b_order %0d: got %h want %h", k, seen[k], words[k]);
                end
            end
        end
    endtask

    task automatic test_credits();
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 32'h0, 5'd0, '0, 1'b1, 1'b0, 3'b000);
            commit();
            idle(3'b000);
            checks++;
            if (out_credits !== CW'(k)) begin
                errors++;
                $display("FAIL credit_inc %0d: got %0d want %0d", k, out_credits, k);
            end
        end
        checks++;
        if (credits_full !== 1'b1) begin
            errors++;
            $display("FAIL credit_full: got %b want 1", credits_full);
        end
        apply(1'b1, 32'h5555_0000, 5'd3, '0, 1'b1, 1'b0, 3'b000);
        commit();
        idle(3'b111);
        checks++;
        if (out_credits !== CW'(4) || credits_full !== 1'b1) begin
            errors++;
            $display("FAIL credit_net: got %0d/%b want 4/1", out_credits, credits_full);
        end
        commit();
        apply(1'b1, 32'h6666_0000, 5'd4, '0, 1'b0, 1'b1, 3'b000);
        commit();
        idle(3'b111);
        checks++;
        if (out_credits !== CW'(2) || credits_full !== 1'b0) begin
            errors++;
            $display("FAIL credit_dec2: got %0d/%b want 2/0", out_credits, credits_full);
        end
        commit();
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 32'h0, 5'd0, '0, 1'b1, 1'b0, 3'b000);
        commit();
        apply(1'b1, 32'h7777_0000, 5'd7, '0, 1'b0, 1'b0, 3'b000);
        commit();
        apply(1'b1, 32'h8888_0000, 5'd8, '0, 1'b0, 1'b0, 3'b000);
        commit();
        reset = 1'b1;
        idle(3'b000);
        commit();
        reset = 1'b0;
        idle(3'b000);
        checks++;
        if (out_credits !== '0 || credits_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_credits: got %0d/%b want 0/0", out_credits, credits_full);
        end
        checks++;
        if ({ifill_v, float_wb_v, int_wb_v} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_valids: got %b want 000", {ifill_v, float_wb_v, int_wb_v});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r;
            logic [31:0] w;
            logic        v;
            logic        ack;
            logic        send;
            int          acc;
            logic [2:0]  exp_v;
            logic [31:0] exp_d;
            logic [31:0] got_d;
            int          p;
            r = $urandom();
            w = $urandom();
            v    = r[0] && credits_m >= 1;
            acc  = (v && q.size() < 2) ? 1 : 0;
            ack  = r[1] && r[2] && (credits_m - acc >= 1);
            send = r[3] && (credits_m - acc - int'(ack) < MAXC);
            apply(v, w, r[8:4], bsg_manycore_load_info_s'(r[15:9]), send, ack, r[18:16]);
            checks++;
            if (returned_yumi !== exp_ryumi()) begin
                errors++;
                $display("FAIL rand_yumi %0d: got %b want %b", c, returned_yumi, exp_ryumi());
            end
            checks++;
            if (out_credits !== CW'(credits_m) || credits_full !== (credits_m == MAXC)) begin
                errors++;
                $display("FAIL rand_credits %0d: got %0d/%b want %0d", c, out_credits, credits_full, credits_m);
            end
            exp_v = 3'b000;
            if (q.size() > 0) exp_v = 3'b001 << port_of(q[0].info);
            checks++;
            if ({ifill_v, float_wb_v, int_wb_v} !== exp_v) begin
                errors++;
                $display("FAIL rand_valid %0d: got %b want %b", c, {ifill_v, float_wb_v, int_wb_v}, exp_v);
            end
            if (q.size() > 0) begin
                p = port_of(q[0].info);
                exp_d = (p == 0) ? expect_int(q[0].word, q[0].info) : q[0].word;
                got_d = (p == 0) ? int_wb_data : (p == 1) ? float_wb_data : ifill_data;
                checks++;
                if (got_d !== exp_d) begin
                    errors++;
                    $display("FAIL rand_data %0d: got %h want %h", c, got_d, exp_d);
                end
            end
            commit();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle(3'b000);
        test_reset();
        test_routing();
        test_hold();
        test_back_to_back();
        test_credits();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
